cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the common data bus among functional units (adders, multipliers, loaders, storers, branch) that have finished execution.
- Each cycle, grants one requesting FU with a round-robin policy.
- Broadcasts the winner's result, address and reorder-buffer index to the reorder buffer and reservation stations.
- Accepts per-FU flush from the reorder buffer so squashed results are never broadcast.

Parameters:
- FU_NUM, 8, number of functional units (requesters).
- WORD_SIZE, 32, data/address width.
- RB_SIZE, 16, reorder-buffer entries.
- RB_INDEX, 4, reorder-buffer index width (log2 RB_SIZE).
- FU_INDEX, 3, FU index width (log2 FU_NUM).
- PRIO_FU, 7, FU given priority when CDB_ARB_PRIO_EN is defined.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  FU_NUM  per-FU result-ready request.
- req_data  input  FU_NUM*WORD_SIZE  FU results, FU i at bits [i*WORD_SIZE +: WORD_SIZE].
- req_addr  input  FU_NUM*WORD_SIZE  store/branch target address per FU, same packing.
- req_rbidx  input  FU_NUM*RB_INDEX  destination RB entry per FU.
- flush  input  FU_NUM  squash from reorder buffer (its reset_out vector).
- grant  output  FU_NUM  one-hot grant, one-cycle pulse.
- cdb_valid  output  1  broadcast valid.
- cdb_fu  output  FU_INDEX  winning FU.
- cdb_rbidx  output  RB_INDEX  RB entry being written.
- cdb_data  output  WORD_SIZE  broadcast data.
- cdb_addr  output  WORD_SIZE  broadcast address.
- cdb_slot_valid  output  RB_SIZE  one-hot decode of cdb_rbidx, gated by cdb_valid.
- conflicts  output  16  saturating count of cycles where at least one request lost arbitration.

Behaviour:
- Reset (reset=0, async):
  - grant=0, cdb_valid=0, cdb_fu=0, cdb_rbidx=0, cdb_data=0, cdb_addr=0, cdb_slot_valid=0, conflicts=0.
  - Round-robin pointer rr=0; last-grant mask=0.
  - Reset asserted mid-broadcast clears all outputs immediately, without waiting for clk.
- Eligible set at each posedge: E = req & ~flush & ~last_grant.
  - last_grant is the grant vector registered at the previous edge.
  - This masks the FU still holding req during the cycle its grant is visible.
- Winner selection: the first i in E scanning rr, rr+1, ... modulo FU_NUM.
- If E is non-zero, registered on the same edge:
  - grant = one-hot(winner).
  - cdb_valid = 1; cdb_fu, cdb_rbidx, cdb_data, cdb_addr = the winner's slices.
  - cdb_slot_valid = 1 << cdb_rbidx.
  - rr = (winner+1) mod FU_NUM, wrapping from FU_NUM-1 to 0.
- If E is zero: grant=0, cdb_valid=0, cdb_slot_valid=0, rr unchanged. cdb_data, cdb_addr, cdb_rbidx and cdb_fu hold their previous values.
- Latency: a request sampled at edge N is broadcast in the cycle after edge N; outputs are valid for exactly one cycle.
- FU handshake:
  - The FU holds req and its data stable until it sees grant[i]=1.
  - It drops req, or presents a new result, by the following edge.
  - Re-grant to the same FU on back-to-back edges is impossible.
- Fairness: any continuously held, unflushed request is granted within FU_NUM edges after it first becomes eligible.
- Flush:
  - flush[i]=1 at an edge excludes FU i from that edge's arbitration only.
  - A broadcast already registered is not retracted.
  - The reorder buffer discards stale entries itself.
- conflicts increments by 1 on each edge where popcount(E) >= 2, saturating at 16'hFFFF.

Optional Feature:
- Macro: CDB_ARB_PRIO_EN.
- Defined: if E[PRIO_FU]=1, PRIO_FU wins regardless of rr, and rr is not advanced, so branch resolution is never delayed.
- Undefined: pure round-robin as above; PRIO_FU is unused.

Test Plan:
- Reset, then req=8'b0000_0100 with rbidx[2]=5, data[2]=32'h1234 -> next cycle: grant=8'b0000_0100, cdb_valid=1, cdb_fu=2, cdb_rbidx=5, cdb_data=32'h1234, cdb_slot_valid=16'h0020.
- req=8'b0000_0011 held, rr=0 -> FU0 granted at edge 1, FU1 at edge 2, FU0 again at edge 3; no back-to-back grant to the same FU; conflicts=1 after edge 1.
- req=8'hFF held, each FU dropping req one cycle after its grant -> grants 0..7 in order across 8 edges, cdb_valid high all 8 cycles.
- req=8'b0000_1000 with flush=8'b0000_1000 for one cycle -> no grant that edge; FU3 granted at the next edge once flush=0.
- Assert reset (low) mid-cycle while cdb_valid=1 -> cdb_valid=0, grant=0 and conflicts=0 immediately; first request after release is arbitrated from rr=0.
- CDB_ARB_PRIO_EN defined, req=8'b1000_0001, rr=0 -> FU7 granted first and FU0 granted next edge; with the macro undefined, FU0 is granted first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus arbiter. Each clock one finished functional unit is picked
// round-robin, and its result, address and reorder-buffer index are broadcast
// to the reorder buffer and the reservation stations one cycle later.
// Per-FU flush from the reorder buffer keeps squashed results off the bus.
//
// Optional build macro: CDB_ARB_PRIO_EN
//   defined   -> FU PRIO_FU wins whenever it is eligible, and the round-robin
//                pointer is left where it was (branch resolution is never
//                held back behind other units).
//   undefined -> pure round-robin; PRIO_FU is unused.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int FU_NUM    = 8,
   parameter int WORD_SIZE = 32,
   parameter int RB_SIZE   = 16,
   parameter int RB_INDEX  = 4,
   parameter int FU_INDEX  = 3,
   parameter int PRIO_FU   = 7
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [FU_NUM-1:0]             req,
   input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
   input  logic [FU_NUM*WORD_SIZE-1:0]   req_addr,
   input  logic [FU_NUM*RB_INDEX-1:0]    req_rbidx,
   input  logic [FU_NUM-1:0]             flush,
   output logic [FU_NUM-1:0]             grant,
   output logic                          cdb_valid,
   output logic [FU_INDEX-1:0]           cdb_fu,
   output logic [RB_INDEX-1:0]           cdb_rbidx,
   output logic [WORD_SIZE-1:0]          cdb_data,
   output logic [WORD_SIZE-1:0]          cdb_addr,
   output logic [RB_SIZE-1:0]            cdb_slot_valid,
   output logic [15:0]                   conflicts
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [FU_NUM-1:0]    grant_q,     grant_d;
   logic [FU_INDEX-1:0]  rr_q,        rr_d;
   logic                 cdb_valid_q, cdb_valid_d;
   logic [FU_INDEX-1:0]  cdb_fu_q,    cdb_fu_d;
   logic [RB_INDEX-1:0]  cdb_rbidx_q, cdb_rbidx_d;
   logic [WORD_SIZE-1:0] cdb_data_q,  cdb_data_d;
   logic [WORD_SIZE-1:0] cdb_addr_q,  cdb_addr_d;
   logic [RB_SIZE-1:0]   slot_q,      slot_d;
   logic [15:0]          conflicts_q, conflicts_d;

   // ---------------------------------------------------------------------------
   // Arbitration datapath
   // ---------------------------------------------------------------------------
   logic [FU_NUM-1:0]    eligible;
   logic                 multi_req;
   logic                 win_found;
   logic [FU_INDEX-1:0]  win_idx;
   logic [FU_INDEX-1:0]  win_next;
   logic                 prio_hit;
   logic [WORD_SIZE-1:0] win_data;
   logic [WORD_SIZE-1:0] win_addr;
   logic [RB_INDEX-1:0]  win_rbidx;

   // The grant registered at the previous edge is still visible to its FU,
   // which may keep req high for that cycle; masking it prevents a double grant.
   assign eligible = req & ~flush & ~grant_q;

   // Two or more eligible bits: clearing the lowest set bit leaves something.
   assign multi_req = (eligible & (eligible - {{(FU_NUM-1){1'b0}}, 1'b1})) != '0;

   // Round-robin scan starting at rr_q, wrapping modulo FU_NUM.
   always_comb begin
      int sum;
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < FU_NUM; k++) begin
         sum = int'(rr_q) + k;
         if (sum >= FU_NUM) sum = sum - FU_NUM;
         if (!win_found && eligible[FU_INDEX'(sum)]) begin
            win_found = 1'b1;
            win_idx   = FU_INDEX'(sum);
         end
      end
`ifdef CDB_ARB_PRIO_EN
      prio_hit = eligible[PRIO_FU];
      if (prio_hit) begin
         win_found = 1'b1;
         win_idx   = FU_INDEX'(PRIO_FU);
      end
`else
      prio_hit = 1'b0;
`endif
   end

   // Pointer successor of the winner, wrapping from FU_NUM-1 back to 0.
   assign win_next = (win_idx == FU_INDEX'(FU_NUM - 1)) ? '0 : win_idx + 1'b1;

   // Winner's payload slices.
   assign win_data  = req_data[win_idx*WORD_SIZE +: WORD_SIZE];
   assign win_addr  = req_addr[win_idx*WORD_SIZE +: WORD_SIZE];
   assign win_rbidx = req_rbidx[win_idx*RB_INDEX +: RB_INDEX];

   // Next-state for grant, broadcast payload, pointer and conflict counter.
   always_comb begin
      grant_d     = '0;
      cdb_valid_d = 1'b0;
      slot_d      = '0;
      rr_d        = rr_q;
      // The payload holds its previous value on idle cycles.
      cdb_fu_d    = cdb_fu_q;
      cdb_rbidx_d = cdb_rbidx_q;
      cdb_data_d  = cdb_data_q;
      cdb_addr_d  = cdb_addr_q;
      conflicts_d = conflicts_q;

      if (win_found) begin
         grant_d[win_idx]   = 1'b1;
         cdb_valid_d        = 1'b1;
         cdb_fu_d           = win_idx;
         cdb_rbidx_d        = win_rbidx;
         cdb_data_d         = win_data;
         cdb_addr_d         = win_addr;
         slot_d[win_rbidx]  = 1'b1;
         // A priority win leaves the rotation untouched.
         if (!prio_hit) rr_d = win_next;
      end

      if (multi_req && (conflicts_q != 16'hFFFF)) begin
         conflicts_d = conflicts_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // Arbitration state: last grant mask and round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: all registers here are control/payload flops (no memory arrays),
      // so every one is cleared by the asynchronous reset.
      if (!reset) begin
         grant_q <= '0;
         rr_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   // Broadcast registers and the saturating conflict counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_valid_q <= 1'b0;
         cdb_fu_q    <= '0;
         cdb_rbidx_q <= '0;
         cdb_data_q  <= '0;
         cdb_addr_q  <= '0;
         slot_q      <= '0;
         conflicts_q <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_fu_q    <= cdb_fu_d;
         cdb_rbidx_q <= cdb_rbidx_d;
         cdb_data_q  <= cdb_data_d;
         cdb_addr_q  <= cdb_addr_d;
         slot_q      <= slot_d;
         conflicts_q <= conflicts_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (all registered)
   // ---------------------------------------------------------------------------
   assign grant          = grant_q;
   assign cdb_valid      = cdb_valid_q;
   assign cdb_fu         = cdb_fu_q;
   assign cdb_rbidx      = cdb_rbidx_q;
   assign cdb_data       = cdb_data_q;
   assign cdb_addr       = cdb_addr_q;
   assign cdb_slot_valid = slot_q;
   assign conflicts      = conflicts_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Scoreboard bench: a driver issues one input vector per cycle and pushes the
// reference model's expected bus state; a monitor pops one entry after every
// rising edge and compares it with the DUT outputs. Directed scenarios are
// followed by randomized traffic from a simple FU behaviour model.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int FU_NUM    = 8;
   localparam int WORD_SIZE = 32;
   localparam int RB_SIZE   = 16;
   localparam int RB_INDEX  = 4;
   localparam int FU_INDEX  = 3;
   localparam int PRIO_FU   = 7;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [FU_NUM-1:0]           req;
   logic [FU_NUM*WORD_SIZE-1:0] req_data;
   logic [FU_NUM*WORD_SIZE-1:0] req_addr;
   logic [FU_NUM*RB_INDEX-1:0]  req_rbidx;
   logic [FU_NUM-1:0]           flush;
   logic [FU_NUM-1:0]           grant;
   logic                        cdb_valid;
   logic [FU_INDEX-1:0]         cdb_fu;
   logic [RB_INDEX-1:0]         cdb_rbidx;
   logic [WORD_SIZE-1:0]        cdb_data;
   logic [WORD_SIZE-1:0]        cdb_addr;
   logic [RB_SIZE-1:0]          cdb_slot_valid;
   logic [15:0]                 conflicts;

   cdb_arbiter #(
      .FU_NUM(FU_NUM), .WORD_SIZE(WORD_SIZE), .RB_SIZE(RB_SIZE),
      .RB_INDEX(RB_INDEX), .FU_INDEX(FU_INDEX), .PRIO_FU(PRIO_FU)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .req_addr(req_addr), .req_rbidx(req_rbidx), .flush(flush),
      .grant(grant), .cdb_valid(cdb_valid), .cdb_fu(cdb_fu),
      .cdb_rbidx(cdb_rbidx), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
      .cdb_slot_valid(cdb_slot_valid), .conflicts(conflicts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [FU_NUM-1:0]    grant;
      logic                 valid;
      logic [FU_INDEX-1:0]  fu;
      logic [RB_INDEX-1:0]  rbidx;
      logic [WORD_SIZE-1:0] data;
      logic [WORD_SIZE-1:0] addr;
      logic [RB_SIZE-1:0]   slot;
      logic [15:0]          conf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   bit   mon_en = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   // FU behaviour model: pending result per unit.
   bit                   fu_have [FU_NUM];
   logic [WORD_SIZE-1:0] fu_data [FU_NUM];
   logic [WORD_SIZE-1:0] fu_addr [FU_NUM];
   logic [RB_INDEX-1:0]  fu_rb   [FU_NUM];

   // Reference model state (integers, not the RTL encoding).
   int                   m_rr;
   int                   m_last;   // FU granted at the previous edge, -1 if none
   int                   m_conf;
   int                   m_fu;
   int                   m_rb;
   logic [WORD_SIZE-1:0] m_data;
   logic [WORD_SIZE-1:0] m_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_last = -1; m_conf = 0;
      m_fu = 0; m_rb = 0; m_data = '0; m_addr = '0;
   endtask

   // One arbitration edge from the rules: eligible list, rotating scan, counter.
   task automatic model_step(input logic [FU_NUM-1:0] r, input logic [FU_NUM-1:0] f,
                             output exp_t e);
      bit elig [FU_NUM];
      int n_elig = 0;
      int winner = -1;
      bit prio   = 1'b0;
      for (int i = 0; i < FU_NUM; i++) begin
         elig[i] = r[i] && !f[i] && (i != m_last);
         if (elig[i]) n_elig++;
      end
`ifdef CDB_ARB_PRIO_EN
      if (elig[PRIO_FU]) begin
         winner = PRIO_FU;
         prio   = 1'b1;
      end
`endif
      for (int k = 0; k < FU_NUM; k++) begin
         if (winner < 0 && elig[(m_rr + k) % FU_NUM]) winner = (m_rr + k) % FU_NUM;
      end
      if (n_elig >= 2 && m_conf < 65535) m_conf++;
      e.grant = '0;
      e.valid = 1'b0;
      e.slot  = '0;
      if (winner >= 0) begin
         e.grant[winner] = 1'b1;
         e.valid = 1'b1;
         m_fu    = winner;
         m_rb    = int'(fu_rb[winner]);
         m_data  = fu_data[winner];
         m_addr  = fu_addr[winner];
         e.slot[m_rb] = 1'b1;
         if (!prio) m_rr = (winner + 1) % FU_NUM;
      end
      e.fu    = FU_INDEX'(m_fu);
      e.rbidx = RB_INDEX'(m_rb);
      e.data  = m_data;
      e.addr  = m_addr;
      e.conf  = 16'(m_conf);
      m_last  = winner;
   endtask

   // Drive one cycle's inputs at the falling edge and queue the expectation.
   task automatic drive(input logic [FU_NUM-1:0] r, input logic [FU_NUM-1:0] f);
      exp_t e;
      @(negedge clk);
      req   = r;
      flush = f;
      for (int i = 0; i < FU_NUM; i++) begin
         req_data[i*WORD_SIZE +: WORD_SIZE] = fu_data[i];
         req_addr[i*WORD_SIZE +: WORD_SIZE] = fu_addr[i];
         req_rbidx[i*RB_INDEX +: RB_INDEX]  = fu_rb[i];
      end
      model_step(r, f, e);
      sb_q.push_back(e);
   endtask

   task automatic new_result(input int i);
      fu_have[i] = 1'b1;
      fu_data[i] = $urandom;
      fu_addr[i] = $urandom;
      fu_rb[i]   = RB_INDEX'($urandom_range(RB_SIZE - 1));
   endtask

   // Randomized FU behaviour: hold until granted, then drop or offer a new result.
   task automatic rand_cycle();
      logic [FU_NUM-1:0] r;
      logic [FU_NUM-1:0] f;
      for (int i = 0; i < FU_NUM; i++) begin
         if (m_last == i) begin
            if ($urandom_range(1) == 1) new_result(i);
            else fu_have[i] = 1'b0;
         end else if (!fu_have[i] && $urandom_range(3) == 0) begin
            new_result(i);
         end
         r[i] = fu_have[i];
         f[i] = ($urandom_range(7) == 0);
      end
      drive(r, f);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      reset  = 1'b0;
      req    = '0;
      flush  = '0;
      sb_q.delete();
      model_reset();
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_valid", cdb_valid, 0);
      check("rst_fu", cdb_fu, 0);
      check("rst_rbidx", cdb_rbidx, 0);
      check("rst_data", cdb_data, 0);
      check("rst_addr", cdb_addr, 0);
      check("rst_slot", cdb_slot_valid, 0);
      check("rst_conflicts", conflicts, 0);
      reset  = 1'b1;
      mon_en = 1'b1;
   endtask

   // Monitor: one expected entry per edge, compared just after the edge.
   always @(posedge clk) begin
      #1;
      if (mon_en && sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("sb_grant", grant, mon_e.grant);
         check("sb_valid", cdb_valid, mon_e.valid);
         check("sb_fu", cdb_fu, mon_e.fu);
         check("sb_rbidx", cdb_rbidx, mon_e.rbidx);
         check("sb_data", cdb_data, mon_e.data);
         check("sb_addr", cdb_addr, mon_e.addr);
         check("sb_slot", cdb_slot_valid, mon_e.slot);
         check("sb_conflicts", conflicts, mon_e.conf);
      end
   end

   // Watchdog: the run is cycle-bounded, this only catches a stuck simulation.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected done", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [FU_NUM-1:0] r;
      reset = 1'b0; req = '0; flush = '0;
      req_data = '0; req_addr = '0; req_rbidx = '0;
      for (int i = 0; i < FU_NUM; i++) begin
         fu_have[i] = 1'b0; fu_data[i] = '0; fu_addr[i] = '0; fu_rb[i] = '0;
      end
      model_reset();
      #12;

      // Single request from FU2.
      do_reset();
      fu_data[2] = 32'h1234; fu_addr[2] = 32'hA0A0_0002; fu_rb[2] = 4'd5;
      drive(8'b0000_0100, 8'h00);
      @(posedge clk); #2;
      check("t1_grant", grant, 8'b0000_0100);
      check("t1_valid", cdb_valid, 1);
      check("t1_fu", cdb_fu, 2);
      check("t1_rbidx", cdb_rbidx, 5);
      check("t1_data", cdb_data, 32'h1234);
      check("t1_slot", cdb_slot_valid, 16'h0020);

      // Two units held high: FU0, FU1, FU0, one conflict.
      do_reset();
      fu_data[0] = 32'hD0; fu_rb[0] = 4'd1;
      fu_data[1] = 32'hD1; fu_rb[1] = 4'd2;
      drive(8'b0000_0011, 8'h00);
      @(posedge clk); #2;
      check("t2_grant_e1", grant, 8'b0000_0001);
      check("t2_conflicts_e1", conflicts, 1);
      drive(8'b0000_0011, 8'h00);
      @(posedge clk); #2;
      check("t2_grant_e2", grant, 8'b0000_0010);
      drive(8'b0000_0011, 8'h00);
      @(posedge clk); #2;
      check("t2_grant_e3", grant, 8'b0000_0001);
      check("t2_conflicts_e3", conflicts, 1);

      // All eight request, each drops after its grant: 0..7 in order.
      do_reset();
      for (int i = 0; i < FU_NUM; i++) new_result(i);
      r = 8'hFF;
      for (int k = 0; k < FU_NUM; k++) begin
         drive(r, 8'h00);
         @(posedge clk); #2;
         check($sformatf("t3_grant_%0d", k), grant, 64'(1) << k);
         check($sformatf("t3_valid_%0d", k), cdb_valid, 1);
         r[k] = 1'b0;
      end

      // Flushed for one edge, granted on the next.
      do_reset();
      new_result(3);
      drive(8'b0000_1000, 8'b0000_1000);
      @(posedge clk); #2;
      check("t4_no_grant", grant, 0);
      check("t4_no_valid", cdb_valid, 0);
      drive(8'b0000_1000, 8'h00);
      @(posedge clk); #2;
      check("t4_grant", grant, 8'b0000_1000);

      // Asynchronous reset mid-broadcast, then arbitration restarts at rr=0.
      do_reset();
      new_result(5); new_result(1); new_result(4);
      drive(8'b0011_0010, 8'h00);
      drive(8'b0010_0000, 8'h00);
      @(posedge clk); #2;
      check("t5_valid_before", cdb_valid, 1);
      check("t5_grant_before", grant, 8'b0010_0000);
      reset = 1'b0;
      #1;
      check("t5_async_valid", cdb_valid, 0);
      check("t5_async_grant", grant, 0);
      check("t5_async_conflicts", conflicts, 0);
      check("t5_async_slot", cdb_slot_valid, 0);
      do_reset();
      new_result(0); new_result(6);
      drive(8'b0100_0001, 8'h00);
      @(posedge clk); #2;
      check("t5_after_rr0", grant, 8'b0000_0001);

      // FU7 against FU0 from rr=0.
      do_reset();
      new_result(0); new_result(7);
      drive(8'b1000_0001, 8'h00);
      @(posedge clk); #2;
`ifdef CDB_ARB_PRIO_EN
      check("t6_first", grant, 8'b1000_0000);
      drive(8'b0000_0001, 8'h00);
      @(posedge clk); #2;
      check("t6_second", grant, 8'b0000_0001);
`else
      check("t6_first", grant, 8'b0000_0001);
      drive(8'b1000_0000, 8'h00);
      @(posedge clk); #2;
      check("t6_second", grant, 8'b1000_0000);
`endif

      // Randomized traffic, with one reset in the middle.
      do_reset();
      for (int i = 0; i < FU_NUM; i++) fu_have[i] = 1'b0;
      for (int n = 0; n < 1500; n++) rand_cycle();
      do_reset();
      for (int i = 0; i < FU_NUM; i++) fu_have[i] = 1'b0;
      for (int n = 0; n < 1500; n++) rand_cycle();

      @(posedge clk); #2;
      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
